// File: rtl/phase_sweep_gen.sv
// phase_sweep_gen
// Phase generator that feeds a downstream CORDIC. It produces either a fixed
// tone (constant tuning word) or a linear frequency sweep (the tuning word
// grows by a fixed step on every sample).
//
// Ports
//   clk           : single clock, rising edge
//   reset_n       : asynchronous active-low reset
//   enable        : clock enable shared with the CORDIC; all state freezes when low
//   start         : begin generation (only honoured in IDLE)
//   stop          : abort generation (wins over start and over completion)
//   i_mode        : 0 = fixed tone, 1 = linear sweep (sampled at start)
//   i_ftw_start   : initial frequency tuning word (sampled at start)
//   i_ftw_step    : per-sample tuning-word increment in sweep mode (sampled at start)
//   i_sweep_len   : number of sweep samples L (sampled at start)
//   o_phase       : registered phase, top PW bits of the accumulator
//   o_phase_valid : o_phase holds a valid sample
//   o_data_valid  : o_phase_valid delayed by NSTAGES enabled cycles
//   o_busy        : high while in TONE or SWEEP
//   o_done        : one-enabled-cycle pulse at normal sweep completion
module phase_sweep_gen #(
    parameter int PW      = 12,
    parameter int AW      = 32,
    parameter int NSTAGES = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          start,
    input  logic          stop,
    input  logic          i_mode,
    input  logic [AW-1:0] i_ftw_start,
    input  logic [AW-1:0] i_ftw_step,
    input  logic [15:0]   i_sweep_len,
    output logic [PW-1:0] o_phase,
    output logic          o_phase_valid,
    output logic          o_data_valid,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] acc_reg;
    logic [AW-1:0] ftw_reg;
    logic [AW-1:0] step_reg;
    logic [15:0]   cnt_reg;
    logic [15:0]   len_reg;
    logic [PW-1:0] phase_reg;
    logic          valid_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [NSTAGES-1:0] dly_reg;

    // Control FSM with registered outputs.
    // Sample 0 (phase 0) is emitted on the start edge itself. The accumulator
    // is then loaded with the first tuning word, so each later edge outputs
    // the running sum of all tuning words used so far.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            ftw_reg   <= '0;
            step_reg  <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            phase_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (enable) begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (start && !stop) begin
                        if (i_mode && (i_sweep_len == 16'd0)) begin
                            // Empty sweep: completes immediately, nothing emitted.
                            done_reg <= 1'b1;
                        end else begin
                            step_reg  <= i_ftw_step;
                            len_reg   <= i_sweep_len;
                            acc_reg   <= i_ftw_start;
                            ftw_reg   <= i_ftw_start + i_ftw_step;
                            cnt_reg   <= 16'd1;
                            phase_reg <= '0;
                            valid_reg <= 1'b1;
                            busy_reg  <= 1'b1;
                            state_reg <= i_mode ? SWEEP : TONE;
                        end
                    end
                end
                TONE, SWEEP: begin
                    if (stop) begin
                        // Abort: no completion pulse.
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if ((state_reg == SWEEP) && (cnt_reg == len_reg)) begin
                        // All L samples already emitted; this edge only signals completion.
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        phase_reg <= acc_reg[AW-1 -: PW];
                        acc_reg   <= acc_reg + ftw_reg;
                        valid_reg <= 1'b1;
                        if (state_reg == SWEEP) begin
                            ftw_reg <= ftw_reg + step_reg;
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Valid delay line matching the CORDIC pipeline depth; it advances only on
    // enabled edges so it stays aligned with the CORDIC data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_reg[0] <= 1'b0;
        end else if (enable) begin
            dly_reg[0] <= valid_reg;
        end
    end

    generate
        for (genvar gi = 1; gi < NSTAGES; gi++) begin : g_dly
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dly_reg[gi] <= 1'b0;
                end else if (enable) begin
                    dly_reg[gi] <= dly_reg[gi-1];
                end
            end
        end
    endgenerate

    assign o_phase       = phase_reg;
    assign o_phase_valid = valid_reg;
    assign o_data_valid  = dly_reg[NSTAGES-1];
    assign o_busy        = busy_reg;
    assign o_done        = done_reg;

endmodule

// File: tb/tb_phase_sweep_gen.sv
// Testbench for phase_sweep_gen: a fixed vector table for the basic sweep and
// the short-length corners, then model-driven sequences (tone wrap, stop,
// enable gating, random sweeps, mid-run reset) checked through a scoreboard.
module tb_phase_sweep_gen;

    localparam int PW  = 12;
    localparam int AW  = 32;
    localparam int NST = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          i_mode = 1'b0;
    logic [AW-1:0] i_ftw_start = '0;
    logic [AW-1:0] i_ftw_step = '0;
    logic [15:0]   i_sweep_len = '0;
    logic [PW-1:0] o_phase;
    logic          o_phase_valid;
    logic          o_data_valid;
    logic          o_busy;
    logic          o_done;

    phase_sweep_gen #(.PW(PW), .AW(AW), .NSTAGES(NST)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .start         (start),
        .stop          (stop),
        .i_mode        (i_mode),
        .i_ftw_start   (i_ftw_start),
        .i_ftw_step    (i_ftw_step),
        .i_sweep_len   (i_sweep_len),
        .o_phase       (o_phase),
        .o_phase_valid (o_phase_valid),
        .o_data_valid  (o_data_valid),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] phase;
        logic          valid;
        logic          done;
        logic          busy;
        logic          dv;
    } exp_t;

    typedef struct {
        logic          st;
        logic          sp;
        logic          md;
        logic [AW-1:0] fs;
        logic [AW-1:0] stp;
        logic [15:0]   len;
        exp_t          e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[12];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (0 idle, 1 tone, 2 sweep).
    int              m_state = 0;
    longint unsigned m_n = 0;
    logic [AW-1:0]   m_fs = '0;
    logic [AW-1:0]   m_step = '0;
    int              m_len = 0;
    logic [PW-1:0]   m_phase = '0;
    logic            m_valid = 1'b0;
    logic            m_done = 1'b0;
    logic            m_busy = 1'b0;
    bit              hist[$];

    // Closed form: sample n = sum_{i<n}(fs + i*step) = n*fs + step*n(n-1)/2.
    // Tone runs use step=0, so the tone phase is simply n*fs.
    function automatic logic [PW-1:0] ref_phase(input longint unsigned n);
        longint unsigned s;
        if (m_state == 1) s = n * longint'(m_fs);
        else              s = n * longint'(m_fs) + longint'(m_step) * ((n * (n - 1)) / 2);
        return s[AW-1 -: PW];
    endfunction

    task automatic model_reset();
        m_state = 0; m_n = 0; m_phase = '0; m_valid = 0; m_done = 0; m_busy = 0;
        hist.delete();
    endtask

    task automatic model_step(input logic st, input logic sp, input logic md,
                              input logic [AW-1:0] fs, input logic [AW-1:0] stp,
                              input logic [15:0] len);
        m_done = 1'b0;
        if (m_state == 0) begin
            m_valid = 1'b0;
            if (st && !sp) begin
                if (md && len == 16'd0) begin
                    m_done = 1'b1;
                end else begin
                    m_state = md ? 2 : 1;
                    m_fs = fs; m_step = stp; m_len = int'(len);
                    m_n = 0; m_phase = '0; m_valid = 1'b1; m_busy = 1'b1;
                end
            end
        end else begin
            if (sp) begin
                m_state = 0; m_valid = 1'b0; m_busy = 1'b0;
            end else if (m_state == 2 && (m_n + 1) == longint'(m_len)) begin
                m_state = 0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
            end else begin
                m_n++;
                m_phase = ref_phase(m_n);
                m_valid = 1'b1;
            end
        end
        hist.push_back(m_valid);
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.phase = m_phase; e.valid = m_valid; e.done = m_done; e.busy = m_busy;
        e.dv = (hist.size() > NST) ? hist[hist.size() - NST - 1] : 1'b0;
        return e;
    endfunction

    task automatic drive(input logic st, input logic sp, input logic md,
                         input logic [AW-1:0] fs, input logic [AW-1:0] stp,
                         input logic [15:0] len, input logic en);
        @(negedge clk);
        start = st; stop = sp; i_mode = md; i_ftw_start = fs; i_ftw_step = stp;
        i_sweep_len = len; enable = en;
    endtask

    task automatic settle_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            if (o_phase !== e.phase || o_phase_valid !== e.valid || o_done !== e.done ||
                o_busy !== e.busy || o_data_valid !== e.dv) begin
                n_fail++;
                $display("FAIL %s: got ph=%03h v=%b d=%b b=%b dv=%b, want ph=%03h v=%b d=%b b=%b dv=%b",
                         tag, o_phase, o_phase_valid, o_done, o_busy, o_data_valid,
                         e.phase, e.valid, e.done, e.busy, e.dv);
            end else begin
                $display("[TB] %s ph=%03h v=%b d=%b b=%b dv=%b", tag, o_phase,
                         o_phase_valid, o_done, o_busy, o_data_valid);
            end
        end
    endtask

    task automatic txn(input logic st, input logic sp, input logic md,
                       input logic [AW-1:0] fs, input logic [AW-1:0] stp,
                       input logic [15:0] len, input logic en, input string tag);
        drive(st, sp, md, fs, stp, len, en);
        if (en) model_step(st, sp, md, fs, stp, len);
        sb_q.push_back(model_exp());
        settle_check(tag);
    endtask

    task automatic idle_txns(input int n, input logic en, input string tag);
        for (int k = 0; k < n; k++) txn(0, 0, 0, '0, '0, '0, en, tag);
    endtask

    task automatic check_zero(input string tag);
        n_tests++;
        if (o_phase !== '0 || o_phase_valid !== 1'b0 || o_data_valid !== 1'b0 ||
            o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got ph=%03h v=%b dv=%b b=%b d=%b, want all 0",
                     tag, o_phase, o_phase_valid, o_data_valid, o_busy, o_done);
        end else begin
            $display("[TB] %s all outputs 0", tag);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_vec(input int i, input logic st, input logic sp, input logic md,
                           input logic [AW-1:0] fs, input logic [AW-1:0] stp,
                           input logic [15:0] len, input logic [PW-1:0] ph,
                           input logic v, input logic d, input logic b, input logic dv);
        tbl[i].st = st; tbl[i].sp = sp; tbl[i].md = md; tbl[i].fs = fs;
        tbl[i].stp = stp; tbl[i].len = len;
        tbl[i].e.phase = ph; tbl[i].e.valid = v; tbl[i].e.done = d;
        tbl[i].e.busy = b; tbl[i].e.dv = dv;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Sweep fs=0 step=0x100000 L=4 -> 0,0,1,3 then done; L=0; L=1; start+stop in IDLE.
        //          st sp md fs            step          len   ph      v  d  b  dv
        set_vec(0,  1, 0, 1, 32'h0,        32'h0010_0000, 16'd4, 12'h000, 1, 0, 1, 0);
        set_vec(1,  0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h000, 1, 0, 1, 0);
        set_vec(2,  0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h001, 1, 0, 1, 0);
        set_vec(3,  0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h003, 1, 0, 1, 0);
        set_vec(4,  0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h003, 0, 1, 0, 0);
        set_vec(5,  0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h003, 0, 0, 0, 0);
        set_vec(6,  1, 0, 1, 32'h0,        32'h0010_0000, 16'd0, 12'h003, 0, 1, 0, 0);
        set_vec(7,  0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h003, 0, 0, 0, 0);
        set_vec(8,  1, 0, 1, 32'h1234_5678, 32'h0000_0100, 16'd1, 12'h000, 1, 0, 1, 0);
        set_vec(9,  0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h000, 0, 1, 0, 0);
        set_vec(10, 0, 0, 0, 32'h0,        32'h0,         16'd0, 12'h000, 0, 0, 0, 0);
        set_vec(11, 1, 1, 1, 32'h0100_0000, 32'h0,        16'd5, 12'h000, 0, 0, 0, 1);

        // Reset state
        #12;
        check_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].fs, tbl[i].stp, tbl[i].len, 1'b1);
            sb_q.push_back(tbl[i].e);
            settle_check($sformatf("vec%0d", i));
        end

        mid_reset("reset_idle");

        // Tone: 0x010 per sample, wraps to 0x000 at sample 256.
        txn(1, 0, 0, 32'h0100_0000, 32'h0, 16'd0, 1, "tone_start");
        idle_txns(259, 1, "tone");
        txn(0, 1, 0, '0, '0, '0, 1, "tone_stop");
        idle_txns(2, 1, "tone_idle");

        // Stop after sample 2 of L=8: no done pulse.
        txn(1, 0, 1, 32'h0020_0000, 32'h0001_0000, 16'd8, 1, "stop_start");
        idle_txns(2, 1, "stop_run");
        txn(0, 1, 0, '0, '0, '0, 1, "stop_abort");
        idle_txns(2, 1, "stop_idle");

        // start+stop together in IDLE stays IDLE; start while running is ignored.
        txn(1, 1, 0, 32'h0100_0000, '0, 16'd3, 1, "start_stop_idle");
        txn(1, 0, 1, 32'h0040_0000, 32'h0002_0000, 16'd6, 1, "restart_start");
        for (int k = 0; k < 7; k++)
            txn(1, 0, 0, 32'h0800_0000, 32'h0, 16'd2, 1, "restart_ignored");
        idle_txns(1, 1, "restart_idle");

        // Enable gating mid-sweep, then run through done and the delay-line tail.
        txn(1, 0, 1, 32'h0080_0000, 32'h0003_0000, 16'd20, 1, "gate_start");
        idle_txns(5, 1, "gate_run");
        idle_txns(5, 0, "gate_frozen");
        idle_txns(30, 1, "gate_resume");

        // o_done holds while enable is low.
        txn(1, 0, 1, 32'h0100_0000, 32'h0010_0000, 16'd2, 1, "done_hold_start");
        idle_txns(2, 1, "done_hold_run");
        idle_txns(3, 0, "done_hold_frozen");
        idle_txns(2, 1, "done_hold_release");

        // Random sweeps.
        for (int r = 0; r < 4; r++) begin
            logic [AW-1:0] fs;
            logic [AW-1:0] stp;
            logic [15:0]   len;
            fs  = $urandom;
            stp = $urandom;
            len = 16'($urandom_range(1, 12));
            txn(1, 0, 1, fs, stp, len, 1, $sformatf("rand%0d_start", r));
            idle_txns(int'(len) + 1, 1, $sformatf("rand%0d", r));
        end

        // Reset in the middle of a sweep, then a fresh short sweep.
        txn(1, 0, 1, 32'h0300_0000, 32'h0001_0000, 16'd30, 1, "rst_sweep_start");
        idle_txns(4, 1, "rst_sweep_run");
        mid_reset("async_reset_mid_sweep");
        idle_txns(2, 1, "post_reset_idle");
        txn(1, 0, 1, 32'h0010_0000, 32'h0010_0000, 16'd3, 1, "post_reset_start");
        idle_txns(16, 1, "post_reset_run");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sweep_gen.md
PHASE_SWEEP_GEN -- requirements
Module: phase_sweep_gen

Interface
REQ-001 SHALL have parameter PW, default 12: output phase width; full circle = 2^PW.
REQ-002 SHALL have parameter AW, default 32: phase accumulator and tuning-word width.
REQ-003 SHALL have parameter NSTAGES, default 11: downstream CORDIC stage count; sets the data-valid delay.
REQ-004 SHALL have port clk, input, 1: the single clock; all flops on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1: clock enable shared with the downstream CORDIC; all state frozen when 0.
REQ-007 SHALL have port start, input, 1: begin generation; accepted only in IDLE.
REQ-008 SHALL have port stop, input, 1: abort generation.
REQ-009 SHALL have port i_mode, input, 1: 0 = fixed tone, 1 = linear sweep; sampled at start.
REQ-010 SHALL have port i_ftw_start, input, AW: initial frequency tuning word; sampled at start.
REQ-011 SHALL have port i_ftw_step, input, AW: per-sample FTW increment in sweep mode; sampled at start.
REQ-012 SHALL have port i_sweep_len, input, 16: number of sweep samples L; sampled at start.
REQ-013 SHALL have port o_phase, output, PW: registered phase to the CORDIC i_phase input.
REQ-014 SHALL have port o_phase_valid, output, 1: o_phase holds a valid sample.
REQ-015 SHALL have port o_data_valid, output, 1: o_phase_valid delayed by NSTAGES enabled cycles; marks valid CORDIC outputs.
REQ-016 SHALL have port o_busy, output, 1: high in TONE or SWEEP.
REQ-017 SHALL have port o_done, output, 1: one-enabled-cycle pulse at normal sweep completion.

Function
REQ-018 SHALL implement FSM states IDLE, TONE, SWEEP; all transitions and register updates occur only on rising edges with enable=1.
REQ-019 SHALL, on an IDLE edge with start=1, stop=0: latch inputs, set o_phase=0 and o_phase_valid=1 (sample 0), set acc=i_ftw_start, ftw=i_ftw_start+i_ftw_step, cnt=1, and go to TONE (i_mode=0) or SWEEP (i_mode=1).
REQ-020 SHALL, on each subsequent edge in TONE/SWEEP: o_phase <= acc[AW-1:AW-PW] (truncation), acc <= acc+ftw mod 2^AW, o_phase_valid <= 1.
REQ-021 SHALL, in SWEEP, also update ftw <= ftw+step mod 2^AW and cnt <= cnt+1 per emitted sample; in TONE, ftw and cnt are held.
REQ-022 SHALL give sample n phase = top PW bits of (sum over i<n of ftw_i) mod 2^AW, where ftw_i = i_ftw_start + i*i_ftw_step.
REQ-023 SHALL, on a SWEEP edge with cnt==L: emit no sample, set o_phase_valid=0, pulse o_done=1, and go to IDLE.
REQ-024 SHALL, for L=0 at start in sweep mode: emit no sample, pulse o_done, and remain IDLE.
REQ-025 SHALL, on stop=1 in TONE/SWEEP: go to IDLE with o_phase_valid=0 and no o_done; stop has priority over completion.
REQ-026 SHALL, on start and stop both high in IDLE: stop wins and state stays IDLE; start in TONE/SWEEP is ignored.
REQ-027 SHALL hold o_phase at its last value in IDLE; o_done SHALL be 0 except on the pulse edge.
REQ-028 SHALL implement o_data_valid as an NSTAGES-deep shift register of o_phase_valid, advancing only when enable=1.
REQ-029 SHALL, when enable=0, hold all outputs and the delay line, including o_done.

Reset
REQ-030 SHALL, on reset_n low, immediately clear state to IDLE and clear o_phase, o_phase_valid, o_data_valid, o_busy, o_done, acc, ftw, cnt and the delay line to 0.
REQ-031 SHALL abort any run on reset mid-operation, with no o_done pulse; operation resumes on the first enabled edge after release.

Verification
REQ-032 SHALL verify tone: AW=32, PW=12, ftw=0x01000000, mode 0 -> o_phase 0x000, 0x010, 0x020, ...; 0xFF0 then wraps to 0x000 at sample 256.
REQ-033 SHALL verify sweep: ftw_start=0, step=0x00100000, L=4 -> phases 0, 0, 1, 3 on edges t0..t3; t4 gives valid=0, o_done=1, busy 1->0.
REQ-034 SHALL verify L=0 and L=1: L=0 gives an o_done pulse with no valid; L=1 gives one sample (phase 0) then o_done on the next edge.
REQ-035 SHALL verify enable gating: enable low for 5 cycles mid-sweep -> outputs frozen; sequence resumes identically; o_data_valid tracks o_phase_valid exactly 11 enabled edges later.
REQ-036 SHALL verify stop at sample 2 of L=8 -> valid 0 next edge, no o_done; simultaneous start+stop in IDLE -> stays IDLE.
REQ-037 SHALL verify reset_n asserted mid-sweep -> all outputs 0 asynchronously, before the next clock edge.
